// File: rtl/thunderbird_pkg.sv
// Shared mode encoding and lamp step patterns for the Thunderbird rear lamp sequencer.
package thunderbird_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  localparam logic [2:0] LEFT_STEP1  = 3'b001;
  localparam logic [2:0] LEFT_STEP2  = 3'b011;
  localparam logic [2:0] LEFT_STEP3  = 3'b111;
  localparam logic [2:0] RIGHT_STEP1 = 3'b100;
  localparam logic [2:0] RIGHT_STEP2 = 3'b110;
  localparam logic [2:0] RIGHT_STEP3 = 3'b111;
  localparam logic [2:0] ALL_ON      = 3'b111;
  localparam logic [2:0] ALL_OFF     = 3'b000;

  // Phase 0 is the dark boundary step of every sequence.
  function automatic logic [2:0] left_step(input logic [1:0] phase);
    case (phase)
      2'd1:    return LEFT_STEP1;
      2'd2:    return LEFT_STEP2;
      2'd3:    return LEFT_STEP3;
      default: return ALL_OFF;
    endcase
  endfunction

  function automatic logic [2:0] right_step(input logic [1:0] phase);
    case (phase)
      2'd1:    return RIGHT_STEP1;
      2'd2:    return RIGHT_STEP2;
      2'd3:    return RIGHT_STEP3;
      default: return ALL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/thunderbird_light_sequencer_tick_prescaler.sv
// Free-running step-rate divider: one-cycle step_tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 67108864
) (
  input  logic clock,
  input  logic reset_n,
  output logic step_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Explicit wrap so non-power-of-two dividers keep an exact period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + CW'(1);
  end

  assign step_tick = (cnt_q == LAST);

endmodule

// File: rtl/thunderbird_light_sequencer.sv
// Thunderbird rear lamp controller: synchronizes switches, arbitrates the request
// and steps the two 3-lamp banks through their patterns on each prescaler tick.
module thunderbird_light_sequencer
  import thunderbird_pkg::*;
#(
  parameter int TICK_DIV = 67108864
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sign_left,
  input  logic       sign_right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] L,
  output logic [2:0] R,
  output logic [1:0] active_mode,
  output logic       step_tick
);

  // {brake, hazard, right, left}
  logic [3:0] sync1_q, sync2_q;
  logic       left_s, right_s, hazard_s, brake_s;
  mode_e      req;
  mode_e      mode_q;
  logic [1:0] phase_q;
  logic [2:0] lamp_l_q, lamp_r_q, lamp_l_d, lamp_r_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .step_tick(step_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {brake, hazard, sign_right, sign_left};
      sync2_q <= sync1_q;
    end
  end

  assign {brake_s, hazard_s, right_s, left_s} = sync2_q;

  always_comb begin
    req = MODE_IDLE;
    if (hazard_s)                 req = MODE_HAZARD;
    else if (left_s && !right_s)  req = MODE_LEFT;
    else if (right_s && !left_s)  req = MODE_RIGHT;
  end

  // Turn changes wait for the phase-0 boundary; only hazard pre-empts mid-sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_IDLE;
      phase_q <= 2'd0;
    end else if (step_tick) begin
      if (req == MODE_HAZARD && mode_q != MODE_HAZARD) begin
        mode_q  <= MODE_HAZARD;
        phase_q <= 2'd1;
      end else if (mode_q == MODE_IDLE || phase_q == 2'd0) begin
        mode_q  <= req;
        phase_q <= (req == MODE_IDLE) ? 2'd0 : 2'd1;
      end else begin
        phase_q <= phase_q + 2'd1;
      end
    end
  end

  always_comb begin
    lamp_l_d = ALL_OFF;
    lamp_r_d = ALL_OFF;
    case (mode_q)
      MODE_LEFT: begin
        lamp_l_d = left_step(phase_q);
        if (brake_s) lamp_r_d = ALL_ON;
      end
      MODE_RIGHT: begin
        lamp_r_d = right_step(phase_q);
        if (brake_s) lamp_l_d = ALL_ON;
      end
      MODE_HAZARD: begin
        lamp_l_d = phase_q[0] ? ALL_ON : ALL_OFF;
        lamp_r_d = phase_q[0] ? ALL_ON : ALL_OFF;
      end
      default: begin
        if (brake_s) begin
          lamp_l_d = ALL_ON;
          lamp_r_d = ALL_ON;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lamp_l_q <= ALL_OFF;
      lamp_r_q <= ALL_OFF;
    end else begin
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
    end
  end

  assign L           = lamp_l_q;
  assign R           = lamp_r_q;
  assign active_mode = mode_q;

endmodule

// File: tb/tb_thunderbird_light_sequencer.sv
// Randomized + directed bench for thunderbird_light_sequencer against a behavioural model.
module tb_thunderbird_light_sequencer;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sign_left = 1'b0, sign_right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [2:0] L, R;
  logic [1:0] active_mode;
  logic       step_tick;

  int n_chk = 0;
  int n_fail = 0;

  thunderbird_light_sequencer #(.TICK_DIV(TD)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sign_left  (sign_left),
    .sign_right (sign_right),
    .hazard     (hazard),
    .brake      (brake),
    .L          (L),
    .R          (R),
    .active_mode(active_mode),
    .step_tick  (step_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0..3, phase 0..3, lamps from arithmetic on the phase.
  int   m_cnt, m_mode, m_phase, m_req;
  bit   m_s1[4], m_s2[4];   // 0 left, 1 right, 2 hazard, 3 brake
  int   m_L, m_R;

  function automatic int lamps(input int mode, input int ph, input bit brk);
    int l, r;
    l = 0; r = 0;
    case (mode)
      1: begin l = (1 << ph) - 1;  if (brk) r = 7; end
      2: begin r = 8 - (8 >> ph);  if (brk) l = 7; end
      3: begin l = (ph % 2) ? 7 : 0; r = l; end
      default: if (brk) begin l = 7; r = 7; end
    endcase
    return l * 8 + r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0; m_mode = 0; m_phase = 0; m_L = 0; m_R = 0;
      for (int i = 0; i < 4; i++) begin m_s1[i] = 0; m_s2[i] = 0; end
    end else begin
      m_L = lamps(m_mode, m_phase, m_s2[3]) / 8;
      m_R = lamps(m_mode, m_phase, m_s2[3]) % 8;
      if (m_s2[2])                m_req = 3;
      else if (m_s2[0] != m_s2[1]) m_req = m_s2[0] ? 1 : 2;
      else                        m_req = 0;
      if (m_cnt == TD - 1) begin
        if (m_req == 3 && m_mode != 3) begin m_mode = 3; m_phase = 1; end
        else if (m_mode == 0 || m_phase == 0) begin
          m_mode = m_req; m_phase = (m_req == 0) ? 0 : 1;
        end else m_phase = (m_phase + 1) % 4;
      end
      m_s2 = m_s1;
      m_s1[0] = sign_left; m_s1[1] = sign_right; m_s1[2] = hazard; m_s1[3] = brake;
      m_cnt = (m_cnt + 1) % TD;
    end
  end

  always @(negedge clock) begin
    chk("L", int'(L), m_L);
    chk("R", int'(R), m_R);
    chk("active_mode", int'(active_mode), m_mode);
    chk("step_tick", int'(step_tick), (reset_n && m_cnt == TD - 1) ? 1 : 0);
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic drive(input bit l, input bit r, input bit h, input bit b);
    sign_left = l; sign_right = r; hazard = h; brake = b;
  endtask

  initial begin
    int guard;
    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      step(1);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("rst_L", int'(L), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_mode", int'(active_mode), 0);
    chk("rst_tick", int'(step_tick), 0);

    // Release with left held; literal pins on tick and L timing.
    step(1);
    drive(1, 0, 0, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step(1);
      if (k <= 3) chk("first_tick", int'(step_tick), (k == 3) ? 1 : 0);
      if (k == 5)  begin chk("left_001", int'(L), 1); chk("left_mode", int'(active_mode), 1); end
      if (k == 9)  chk("left_011", int'(L), 3);
      if (k == 13) chk("left_111", int'(L), 7);
      if (k == 17) chk("left_000", int'(L), 0);
      if (k == 21) chk("left_001b", int'(L), 1);
    end
    // Hazard with brake while L=001.
    drive(1, 0, 1, 1);
    step(4);
    chk("haz_L", int'(L), 7);
    chk("haz_R", int'(R), 7);
    step(10);
    drive(0, 0, 0, 1);
    step(20);
    chk("brake_idle_L", int'(L), 7);
    // Brake with right turn, then brake drop.
    drive(0, 1, 0, 1);
    step(24);
    drive(0, 1, 0, 0);
    step(3);
    chk("brake_drop_L", int'(L), 0);
    // Left release / swap mid-sequence.
    drive(1, 0, 0, 0);
    step(18);
    drive(0, 1, 0, 0);
    step(18);
    drive(1, 1, 0, 0);
    step(20);
    chk("conflict_mode", int'(active_mode), 0);
    // Reset during RIGHT phase 2.
    drive(0, 1, 0, 0);
    guard = 0;
    while (!(m_mode == 2 && m_phase == 2) && guard < 40) begin step(1); guard++; end
    chk("reach_right_ph2", guard < 40 ? 1 : 0, 1);
    step(1);
    reset_n = 1'b0;
    #1;
    chk("midrst_R", int'(R), 0);
    chk("midrst_tick", int'(step_tick), 0);
    step(1);
    reset_n = 1'b1;
    step(2);
    chk("rel_tick_early", int'(step_tick), 0);
    step(1);
    chk("rel_tick", int'(step_tick), 1);

    // Random segments, with occasional short reset pulses.
    for (int s = 0; s < 60; s++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
      end
      step($urandom_range(1, 14));
    end
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
